// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one physical memory port between the instruction-side (i_*) and
//   data-side (d_*) requesters. One transaction is in flight at a time. When
//   both sides request together, round-robin picks the winner. The winner's
//   command is registered onto pmem_*, and pmem_resp is routed back to the
//   granted side in the same cycle.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   i_read/i_write      : instruction-side request strobes
//   i_byte_enable/i_address/i_wdata : instruction-side operands
//   i_resp/i_rdata      : instruction-side completion pulse / read data
//   d_*                 : data side, same as i_*
//   pmem_read/pmem_write/pmem_byte_enable/pmem_address/pmem_wdata :
//                         registered command to physical memory
//   pmem_resp/pmem_rdata: physical memory completion / read data
//   protocol_err        : sticky, a granted request had read and write both set
//   timeout_err         : sticky, a granted request waited TIMEOUT cycles
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_read,
    input  logic                i_write,
    input  logic [DATA_W/8-1:0] i_byte_enable,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic                i_resp,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W/8-1:0] d_byte_enable,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_resp,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [DATA_W/8-1:0] pmem_byte_enable,
    output logic [ADDR_W-1:0]   pmem_address,
    output logic [DATA_W-1:0]   pmem_wdata,
    input  logic                pmem_resp,
    input  logic [DATA_W-1:0]   pmem_rdata,
    output logic                protocol_err,
    output logic                timeout_err
);

    localparam int BE_W  = DATA_W / 8;
    // A zero TIMEOUT disables the check; keep the counter one bit wide then.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           r_state;
    logic             r_last_d;   // 1: last contended grant went to D
    logic             r_gnt_d;    // 1: current grant belongs to D
    logic [CNT_W-1:0] r_wait;

    logic              w_i_req, w_d_req, w_pick_d;
    logic              w_sel_rd, w_sel_wr;
    logic [BE_W-1:0]   w_sel_be;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_i_req  = i_read | i_write;
    assign w_d_req  = d_read | d_write;
    // D wins when it is alone, or when both request and I won last time.
    assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);

    assign w_sel_rd    = w_pick_d ? d_read        : i_read;
    assign w_sel_wr    = w_pick_d ? d_write       : i_write;
    assign w_sel_be    = w_pick_d ? d_byte_enable : i_byte_enable;
    assign w_sel_addr  = w_pick_d ? d_address     : i_address;
    assign w_sel_wdata = w_pick_d ? d_wdata       : i_wdata;

    // Completion goes only to the granted side and only while BUSY, so a
    // stray pmem_resp in IDLE never reaches a requester.
    assign i_resp  = (r_state == ST_BUSY) & pmem_resp & ~r_gnt_d;
    assign d_resp  = (r_state == ST_BUSY) & pmem_resp &  r_gnt_d;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= ST_IDLE;
            r_last_d         <= 1'b1;
            r_gnt_d          <= 1'b0;
            r_wait           <= '0;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_byte_enable <= '0;
            pmem_address     <= '0;
            pmem_wdata       <= '0;
            protocol_err     <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_i_req | w_d_req) begin
                        r_gnt_d <= w_pick_d;
                        // Pointer only moves when there was a real contest.
                        if (w_i_req & w_d_req)
                            r_last_d <= w_pick_d;
                        // Read+write together is issued as a write.
                        pmem_write       <= w_sel_wr;
                        pmem_read        <= w_sel_rd & ~w_sel_wr;
                        pmem_byte_enable <= w_sel_be;
                        pmem_address     <= w_sel_addr;
                        pmem_wdata       <= w_sel_wdata;
                        if (w_sel_rd & w_sel_wr)
                            protocol_err <= 1'b1;
                        r_wait  <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (pmem_resp) begin
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        r_wait     <= '0;
                        r_state    <= ST_IDLE;
                    end else if ((TIMEOUT != 0) && (r_wait != TO_VAL)) begin
                        // Saturating wait count; flag on the edge it hits TIMEOUT.
                        r_wait <= r_wait + CNT_W'(1);
                        if (r_wait == TO_VAL - CNT_W'(1))
                            timeout_err <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_read = 0, i_write = 0, d_read = 0, d_write = 0;
    logic [BW-1:0] i_byte_enable = '0, d_byte_enable = '0;
    logic [AW-1:0] i_address = '0, d_address = '0;
    logic [DW-1:0] i_wdata = '0, d_wdata = '0;
    logic          i_resp, d_resp;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          pmem_read, pmem_write;
    logic [BW-1:0] pmem_byte_enable;
    logic [AW-1:0] pmem_address;
    logic [DW-1:0] pmem_wdata;
    logic          pmem_resp = 1'b0;
    logic [DW-1:0] pmem_rdata = '0;
    logic          protocol_err, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: who won the last contest, and sticky error flags.
    bit m_last_d;
    bit m_perr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_byte_enable(i_byte_enable),
        .i_address(i_address), .i_wdata(i_wdata), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_byte_enable(pmem_byte_enable),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .protocol_err(protocol_err), .timeout_err(timeout_err)
    );

    task automatic idle_all();
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        i_byte_enable = '0; d_byte_enable = '0;
        i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0;
        pmem_resp = 0; pmem_rdata = '0;
    endtask

    // Leaves the bench at a negedge with reset released and all inputs idle.
    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        idle_all();
        @(negedge clk);
        rst = 1;
        m_last_d = 1;
        m_perr   = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 0;
        idle_all();
        #1;
        n_tests++;
        if ({pmem_read, pmem_write, i_resp, d_resp, protocol_err, timeout_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%b wr=%b ir=%b dr=%b pe=%b te=%b want all 0",
                     pmem_read, pmem_write, i_resp, d_resp, protocol_err, timeout_err);
        end
        n_tests++;
        if (pmem_address !== '0 || pmem_wdata !== '0 || pmem_byte_enable !== '0) begin
            n_fail++;
            $display("FAIL reset_operands: got addr=%h wd=%h be=%h want 0",
                     pmem_address, pmem_wdata, pmem_byte_enable);
        end
        @(negedge clk);
        rst = 1;
        m_last_d = 1;
        m_perr   = 0;
    endtask

    task automatic test_single_read();
        do_reset();
        d_read = 1; d_address = 32'h0000_1000;
        @(negedge clk);
        n_tests++;
        if (pmem_read !== 1 || pmem_write !== 0 || pmem_address !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL single_read_issue: got rd=%b wr=%b addr=%h want 1 0 00001000",
                     pmem_read, pmem_write, pmem_address);
        end
        repeat (2) @(negedge clk);
        pmem_resp = 1; pmem_rdata = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (d_resp !== 1 || i_resp !== 0 || d_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_read_resp: got dr=%b ir=%b rdata=%h want 1 0 deadbeef",
                     d_resp, i_resp, d_rdata);
        end
        @(negedge clk);
        pmem_resp = 0; d_read = 0;
        n_tests++;
        if (pmem_read !== 0 || d_resp !== 0) begin
            n_fail++;
            $display("FAIL single_read_done: got rd=%b dr=%b want 0 0", pmem_read, d_resp);
        end
    endtask

    task automatic test_write_passthru();
        do_reset();
        i_write = 1; i_byte_enable = 4'b0110; i_wdata = 32'h1234_5678; i_address = 32'h40;
        @(negedge clk);
        n_tests++;
        if (pmem_write !== 1 || pmem_read !== 0 || pmem_byte_enable !== 4'b0110 ||
            pmem_wdata !== 32'h1234_5678 || pmem_address !== 32'h40) begin
            n_fail++;
            $display("FAIL write_passthru: got wr=%b rd=%b be=%b wd=%h addr=%h want 1 0 0110 12345678 40",
                     pmem_write, pmem_read, pmem_byte_enable, pmem_wdata, pmem_address);
        end
        pmem_resp = 1;
        #1;
        n_tests++;
        if (i_resp !== 1 || d_resp !== 0) begin
            n_fail++;
            $display("FAIL write_resp: got ir=%b dr=%b want 1 0", i_resp, d_resp);
        end
        @(negedge clk);
        pmem_resp = 0; i_write = 0;
    endtask

    task automatic test_contention();
        bit exp_d;
        do_reset();
        i_read = 1; i_address = 32'h100;
        d_read = 1; d_address = 32'h200;
        exp_d = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (pmem_read !== 1 || pmem_address !== (exp_d ? 32'h200 : 32'h100)) begin
                n_fail++;
                $display("FAIL contention_grant%0d: got rd=%b addr=%h want 1 %h",
                         k, pmem_read, pmem_address, exp_d ? 32'h200 : 32'h100);
            end
            pmem_resp = 1;
            #1;
            n_tests++;
            if (i_resp !== !exp_d || d_resp !== exp_d) begin
                n_fail++;
                $display("FAIL contention_resp%0d: got ir=%b dr=%b want %b %b",
                         k, i_resp, d_resp, !exp_d, exp_d);
            end
            @(negedge clk);
            pmem_resp = 0;
            n_tests++;
            if (pmem_read !== 0 || pmem_write !== 0) begin
                n_fail++;
                $display("FAIL contention_idle%0d: got rd=%b wr=%b want 0 0", k, pmem_read, pmem_write);
            end
            exp_d = !exp_d;
        end
        i_read = 0; d_read = 0;
    endtask

    // Random traffic against a pending-request model: each side holds at most
    // one outstanding request; the winner follows the round-robin rule.
    task automatic test_random();
        bit            p_v[2], p_rd[2], p_wr[2];
        logic [BW-1:0] p_be[2];
        logic [AW-1:0] p_ad[2];
        logic [DW-1:0] p_wd[2];
        int            served;
        bit            gd, both;
        int            g;
        logic [DW-1:0] rdv;
        do_reset();
        served = -1;
        for (int s = 0; s < 2; s++) p_v[s] = 0;
        for (int it = 0; it < 60; it++) begin
            for (int s = 0; s < 2; s++) begin
                if (!p_v[s] && s != served && $urandom_range(0, 1) == 1) begin
                    int kind;
                    kind = $urandom_range(0, 9);
                    p_v[s]  = 1;
                    p_rd[s] = (kind <= 4) || (kind == 9);
                    p_wr[s] = (kind >= 5);
                    p_be[s] = BW'($urandom);
                    p_ad[s] = $urandom;
                    p_wd[s] = $urandom;
                end
            end
            if (!p_v[0] && !p_v[1]) begin
                g = (served == 0) ? 1 : 0;
                p_v[g] = 1; p_rd[g] = 1; p_wr[g] = 0;
                p_be[g] = '1; p_ad[g] = $urandom; p_wd[g] = $urandom;
            end
            i_read = p_v[0] & p_rd[0]; i_write = p_v[0] & p_wr[0];
            i_byte_enable = p_be[0]; i_address = p_ad[0]; i_wdata = p_wd[0];
            d_read = p_v[1] & p_rd[1]; d_write = p_v[1] & p_wr[1];
            d_byte_enable = p_be[1]; d_address = p_ad[1]; d_wdata = p_wd[1];

            both = p_v[0] & p_v[1];
            gd   = p_v[1] && (!p_v[0] || !m_last_d);
            if (both) m_last_d = gd;
            g = gd ? 1 : 0;
            if (p_rd[g] && p_wr[g]) m_perr = 1;

            @(negedge clk);
            n_tests++;
            if (pmem_write !== p_wr[g] || pmem_read !== (p_rd[g] & !p_wr[g]) ||
                pmem_address !== p_ad[g] || pmem_byte_enable !== p_be[g] || pmem_wdata !== p_wd[g]) begin
                n_fail++;
                $display("FAIL rand_cmd%0d: got rd=%b wr=%b addr=%h be=%h wd=%h want %b %b %h %h %h",
                         it, pmem_read, pmem_write, pmem_address, pmem_byte_enable, pmem_wdata,
                         p_rd[g] & !p_wr[g], p_wr[g], p_ad[g], p_be[g], p_wd[g]);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            rdv = $urandom;
            pmem_resp = 1; pmem_rdata = rdv;
            #1;
            n_tests++;
            if (i_resp !== !gd || d_resp !== gd || i_rdata !== rdv || d_rdata !== rdv) begin
                n_fail++;
                $display("FAIL rand_resp%0d: got ir=%b dr=%b ird=%h drd=%h want %b %b %h",
                         it, i_resp, d_resp, i_rdata, d_rdata, !gd, gd, rdv);
            end
            @(negedge clk);
            pmem_resp = 0;
            p_v[g] = 0;
            served = g;
            if (g == 0) begin i_read = 0; i_write = 0; end
            else        begin d_read = 0; d_write = 0; end
            n_tests++;
            if (pmem_read !== 0 || pmem_write !== 0 || protocol_err !== m_perr || timeout_err !== 0) begin
                n_fail++;
                $display("FAIL rand_idle%0d: got rd=%b wr=%b pe=%b te=%b want 0 0 %b 0",
                         it, pmem_read, pmem_write, protocol_err, timeout_err, m_perr);
            end
        end
        // Drain whatever is still pending so the next test starts clean.
        idle_all();
        @(negedge clk);
        if (pmem_read | pmem_write) begin
            pmem_resp = 1;
            @(negedge clk);
            pmem_resp = 0;
        end
    endtask

    task automatic test_protocol_err();
        do_reset();
        d_read = 1; d_write = 1; d_address = 32'h80; d_wdata = 32'hA5A5_0001; d_byte_enable = 4'hF;
        @(negedge clk);
        n_tests++;
        if (pmem_write !== 1 || pmem_read !== 0 || protocol_err !== 1) begin
            n_fail++;
            $display("FAIL perr_issue: got wr=%b rd=%b pe=%b want 1 0 1", pmem_write, pmem_read, protocol_err);
        end
        pmem_resp = 1;
        @(negedge clk);
        pmem_resp = 0; d_read = 0; d_write = 0;
        repeat (100) @(negedge clk);
        n_tests++;
        if (protocol_err !== 1) begin
            n_fail++;
            $display("FAIL perr_sticky: got pe=%b want 1", protocol_err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        i_read = 1; i_address = 32'h300;
        @(negedge clk);                // first BUSY cycle
        repeat (TO - 1) @(negedge clk);
        n_tests++;
        if (timeout_err !== 0) begin
            n_fail++;
            $display("FAIL timeout_early: got te=%b want 0 after %0d busy cycles", timeout_err, TO - 1);
        end
        @(negedge clk);
        n_tests++;
        if (timeout_err !== 1 || pmem_read !== 1) begin
            n_fail++;
            $display("FAIL timeout_set: got te=%b rd=%b want 1 1 after %0d busy cycles", timeout_err, pmem_read, TO);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (pmem_read !== 1 || timeout_err !== 1) begin
            n_fail++;
            $display("FAIL timeout_wait: got rd=%b te=%b want 1 1", pmem_read, timeout_err);
        end
        pmem_resp = 1;
        @(negedge clk);
        pmem_resp = 0; i_read = 0;
    endtask

    // Runs straight after test_timeout so the sticky error is still set.
    task automatic test_async_reset();
        @(negedge clk);
        i_read = 1; i_address = 32'h500;
        d_read = 1; d_address = 32'h600;
        @(negedge clk);
        pmem_resp = 1;
        #1;
        n_tests++;
        if (i_resp !== 1 || pmem_read !== 1) begin
            n_fail++;
            $display("FAIL arst_pre: got ir=%b rd=%b want 1 1", i_resp, pmem_read);
        end
        #1 rst = 0;
        #1;
        n_tests++;
        if ({pmem_read, pmem_write, i_resp, d_resp, protocol_err, timeout_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: got rd=%b wr=%b ir=%b dr=%b pe=%b te=%b want all 0",
                     pmem_read, pmem_write, i_resp, d_resp, protocol_err, timeout_err);
        end
        @(negedge clk);
        rst = 1; pmem_resp = 0;
        @(negedge clk);
        n_tests++;
        if (pmem_read !== 1 || pmem_address !== 32'h500) begin
            n_fail++;
            $display("FAIL arst_first_grant: got rd=%b addr=%h want 1 00000500", pmem_read, pmem_address);
        end
        pmem_resp = 1;
        @(negedge clk);
        pmem_resp = 0; i_read = 0; d_read = 0;
        @(negedge clk);
        if (pmem_read) begin
            pmem_resp = 1;
            @(negedge clk);
            pmem_resp = 0;
        end
    endtask

    task automatic test_spurious();
        do_reset();
        pmem_resp = 1; pmem_rdata = 32'h5555_AAAA;
        #1;
        n_tests++;
        if (i_resp !== 0 || d_resp !== 0) begin
            n_fail++;
            $display("FAIL spurious_resp: got ir=%b dr=%b want 0 0", i_resp, d_resp);
        end
        @(negedge clk);
        pmem_resp = 0;
        n_tests++;
        if (pmem_read !== 0 || pmem_write !== 0) begin
            n_fail++;
            $display("FAIL spurious_state: got rd=%b wr=%b want 0 0", pmem_read, pmem_write);
        end
        // Still IDLE: a fresh request is granted on the very next edge.
        d_read = 1; d_address = 32'h700;
        @(negedge clk);
        n_tests++;
        if (pmem_read !== 1 || pmem_address !== 32'h700) begin
            n_fail++;
            $display("FAIL spurious_next: got rd=%b addr=%h want 1 00000700", pmem_read, pmem_address);
        end
        pmem_resp = 1;
        @(negedge clk);
        pmem_resp = 0; d_read = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_passthru();
        test_contention();
        test_random();
        test_protocol_err();
        test_spurious();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net: the bench must end on its own even if something stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one physical memory port between an instruction requester (i_*) and a data requester (d_*) in the rv32i CPU memory hierarchy.
- Sits between the CPU's fetch/load-store paths (or their caches) and physical memory.
- Grants one requester at a time, using round-robin on contention.
- Registers the winner's command, forwards the response, and flags protocol errors and timeouts.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 1024, cycles a granted transaction may wait for pmem_resp before timeout_err is set; 0 disables the check.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_read  in  1  instruction-side read request.
- i_write  in  1  instruction-side write request.
- i_byte_enable  in  DATA_W/8  instruction-side byte enables.
- i_address  in  ADDR_W  instruction-side address.
- i_wdata  in  DATA_W  instruction-side write data.
- i_resp  out  1  instruction-side completion pulse.
- i_rdata  out  DATA_W  instruction-side read data.
- d_read, d_write, d_byte_enable, d_address, d_wdata, d_resp, d_rdata: data side, same widths and meanings as the i_* ports.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_byte_enable  out  DATA_W/8  physical memory byte enables.
- pmem_address  out  ADDR_W  physical memory address.
- pmem_wdata  out  DATA_W  physical memory write data.
- pmem_resp  in  1  physical memory completion.
- pmem_rdata  in  DATA_W  physical memory read data.
- protocol_err  out  1  sticky; set when a requester asserts read and write together.
- timeout_err  out  1  sticky; set when a granted transaction exceeds TIMEOUT cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All pmem_* outputs, i_resp, d_resp, protocol_err and timeout_err go to 0.
  - The last-grant pointer is set to D, so the first contended grant goes to I.
  - A reset during BUSY aborts the transaction; no resp is issued.
- Requester protocol: a requester holds its read/write and operands stable from assertion until the cycle it sees resp=1, and deasserts on the following cycle.
- FSM states:
  - IDLE: no grant.
    - No request pending: stay in IDLE.
    - Exactly one of {I, D} requesting (read|write): grant it.
    - Both requesting: grant the port opposite the last-grant pointer, then update the pointer.
    - On grant: capture that port's read, write, byte_enable, address and wdata into the pmem_* output registers, and go to BUSY.
  - BUSY: pmem_* outputs hold their registered values.
    - On pmem_resp=1, the granted side's resp is driven to 1 combinationally in the same cycle.
    - On the next edge: clear pmem_read and pmem_write, clear the wait counter, and return to IDLE.
- Latency:
  - Request seen in IDLE at edge N; pmem strobe high after edge N.
  - Requester resp in the same cycle as pmem_resp.
  - Minimum 2 cycles from request to resp.
  - One IDLE cycle always separates back-to-back grants.
- rdata: i_rdata and d_rdata both equal pmem_rdata at all times. Requesters qualify with their own resp.
- resp gating: the non-granted side's resp is always 0. Both resp outputs are 0 in IDLE, including when a spurious pmem_resp arrives in IDLE.
- Read and write both asserted by one requester at grant:
  - The transaction is issued as a write (pmem_write=1, pmem_read=0).
  - protocol_err is set.
- Timeout:
  - A wait counter (width clog2(TIMEOUT+1), saturating) increments each BUSY cycle while pmem_resp=0.
  - When it reaches TIMEOUT, timeout_err is set.
  - The transaction keeps waiting; there is no forced completion.
- Sticky errors clear only on reset.
- A request that drops before being granted is simply not served. Dropping while granted is a protocol violation; the arbiter ignores it and completes on pmem_resp.

Test Plan:
- Single read: d_read=1, d_address=0x0000_1000. Expect pmem_read=1 with pmem_address=0x0000_1000 one cycle later. Memory returns pmem_resp=1 with rdata 0xDEADBEEF after 3 cycles. Expect d_resp=1 and d_rdata=0xDEADBEEF in that cycle, i_resp=0, and pmem_read=0 on the next cycle.
- Contention round-robin: i_read and d_read held high continuously from reset. Expect grants in the order I, D, I, D over 4 transactions, with one IDLE cycle between each. Each resp goes only to its own side.
- Write pass-through: i_write=1, i_byte_enable=4'b0110, i_wdata=0x1234_5678, i_address=0x40. Expect pmem_write=1, pmem_byte_enable=4'b0110, pmem_wdata=0x1234_5678, pmem_address=0x40, and pmem_read=0.
- Async reset mid-transaction: assert rst=0 between edges while in BUSY. Expect pmem_read, pmem_write, i_resp and d_resp to be 0 immediately, with no clock edge. After release, FSM is in IDLE and the first contended grant goes to I.
- Errors:
  - d_read=1 and d_write=1 together: expect a write issued and protocol_err=1, still 1 after 100 cycles.
  - TIMEOUT=8 with pmem_resp held at 0: expect timeout_err=1 after exactly 8 BUSY cycles.
- Spurious response: pmem_resp=1 while in IDLE. Expect i_resp=0, d_resp=0 and no state change.
